// File: rtl/fwd_stall_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_stall_ctrl
//
// Operand forwarding and hazard/stall control for a five-stage pipeline with
// a multi-cycle mul/div unit.
//
// Forwarding (combinational, also live during reset):
//   ex_rs / ex_rt are resolved against the MEM and WB destinations. A MEM
//   match wins over a WB match. Loads in MEM are not forwarded because their
//   data is not available yet. Register 0 never matches.
//   alu_a   - forwarded rs value
//   alu_b   - ex_imm when ex_alusrc, otherwise the forwarded rt value
//   st_data - forwarded rt value (store data)
//
// Hazards:
//   stall/flush_ex - load-use hazard against the ID sources, or an ID
//                    mul/div / mfhi / mflo while the mul/div unit is busy
//   md_busy        - high for exactly MD_CYCLES cycles after an accepted start
//   stall_cnt      - saturating count of cycles with stall high
//
// Ports: clk, rst_n (asynchronous, active-low); ID inputs id_rs, id_rt,
// id_use_rt, id_md_start, id_hilo_rd; EX inputs ex_rs, ex_rt, ex_rw,
// ex_memtoreg, ex_alusrc, ex_busa, ex_busb, ex_imm; MEM inputs mem_rw,
// mem_regwr, mem_memtoreg, mem_result; WB inputs wb_rw, wb_regwr, wb_din;
// outputs alu_a, alu_b, st_data, stall, flush_ex, md_busy, stall_cnt.
// -----------------------------------------------------------------------------
module fwd_stall_ctrl #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int MD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rt,
    input  logic          id_md_start,
    input  logic          id_hilo_rd,
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] ex_rw,
    input  logic          ex_memtoreg,
    input  logic          ex_alusrc,
    input  logic [DW-1:0] ex_busa,
    input  logic [DW-1:0] ex_busb,
    input  logic [DW-1:0] ex_imm,
    input  logic [AW-1:0] mem_rw,
    input  logic          mem_regwr,
    input  logic          mem_memtoreg,
    input  logic [DW-1:0] mem_result,
    input  logic [AW-1:0] wb_rw,
    input  logic          wb_regwr,
    input  logic [DW-1:0] wb_din,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] st_data,
    output logic          stall,
    output logic          flush_ex,
    output logic          md_busy,
    output logic [DW-1:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Forwarding: index 0 = rs, index 1 = rt
    // -------------------------------------------------------------------------
    logic [AW-1:0] src     [2];
    logic [DW-1:0] rf_val  [2];
    logic [DW-1:0] fwd_val [2];

    assign src[0]    = ex_rs;
    assign src[1]    = ex_rt;
    assign rf_val[0] = ex_busa;
    assign rf_val[1] = ex_busb;

    // A load in MEM has only its address on mem_result, so it must not match.
    logic mem_can_fwd;
    logic wb_can_fwd;
    assign mem_can_fwd = mem_regwr & ~mem_memtoreg & (mem_rw != '0);
    assign wb_can_fwd  = wb_regwr & (wb_rw != '0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit;
            logic wb_hit;
            assign mem_hit     = mem_can_fwd & (mem_rw == src[gi]);
            assign wb_hit      = wb_can_fwd & (wb_rw == src[gi]);
            assign fwd_val[gi] = mem_hit ? mem_result :
                                 wb_hit  ? wb_din     : rf_val[gi];
        end
    endgenerate

    assign alu_a   = fwd_val[0];
    assign alu_b   = ex_alusrc ? ex_imm : fwd_val[1];
    assign st_data = fwd_val[1];

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] stall_cnt_q, stall_cnt_d;
    logic          load_use;
    logic          md_hold;

    assign md_busy  = (state_q == BUSY);
    assign load_use = ex_memtoreg & (ex_rw != '0) &
                      ((ex_rw == id_rs) | (id_use_rt & (ex_rw == id_rt)));
    assign md_hold  = md_busy & (id_md_start | id_hilo_rd);

    // Gated by rst_n so stall reads 0 while reset is held, even if the ID/EX
    // inputs happen to describe a load-use hazard.
    assign stall    = rst_n & (load_use | md_hold);
    assign flush_ex = stall;

    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE: begin
                // A start held off by a stall is simply retried by the
                // pipeline and accepted on the first unstalled cycle.
                if (id_md_start && !stall) begin
                    state_d = BUSY;
                    cnt_d   = MD_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_stall_ctrl
//
// Directed bench for fwd_stall_ctrl. Datapath width is reduced to 8 bits so
// the stall counter can be driven into saturation within a short run.
// -----------------------------------------------------------------------------
module tb_fwd_stall_ctrl;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int MD = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] id_rs, id_rt;
    logic          id_use_rt, id_md_start, id_hilo_rd;
    logic [AW-1:0] ex_rs, ex_rt, ex_rw;
    logic          ex_memtoreg, ex_alusrc;
    logic [DW-1:0] ex_busa, ex_busb, ex_imm;
    logic [AW-1:0] mem_rw;
    logic          mem_regwr, mem_memtoreg;
    logic [DW-1:0] mem_result;
    logic [AW-1:0] wb_rw;
    logic          wb_regwr;
    logic [DW-1:0] wb_din;
    logic [DW-1:0] alu_a, alu_b, st_data, stall_cnt;
    logic          stall, flush_ex, md_busy;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    fwd_stall_ctrl #(.DW(DW), .AW(AW), .MD_CYCLES(MD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rt    (id_use_rt),
        .id_md_start  (id_md_start),
        .id_hilo_rd   (id_hilo_rd),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rw        (ex_rw),
        .ex_memtoreg  (ex_memtoreg),
        .ex_alusrc    (ex_alusrc),
        .ex_busa      (ex_busa),
        .ex_busb      (ex_busb),
        .ex_imm       (ex_imm),
        .mem_rw       (mem_rw),
        .mem_regwr    (mem_regwr),
        .mem_memtoreg (mem_memtoreg),
        .mem_result   (mem_result),
        .wb_rw        (wb_rw),
        .wb_regwr     (wb_regwr),
        .wb_din       (wb_din),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .st_data      (st_data),
        .stall        (stall),
        .flush_ex     (flush_ex),
        .md_busy      (md_busy),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_use_rt = 1'b0; id_md_start = 1'b0; id_hilo_rd = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_rw = '0; ex_memtoreg = 1'b0; ex_alusrc = 1'b0;
        ex_busa = '0; ex_busb = '0; ex_imm = '0;
        mem_rw = '0; mem_regwr = 1'b0; mem_memtoreg = 1'b0; mem_result = '0;
        wb_rw = '0; wb_regwr = 1'b0; wb_din = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // Reset: a load-use pattern on the inputs must not raise stall.
        ex_memtoreg = 1'b1; ex_rw = 5'd9; id_rs = 5'd9;
        #3;
        check("rst_stall", stall, 1'b0);
        check("rst_flush", flush_ex, 1'b0);
        check("rst_md_busy", md_busy, 1'b0);
        check("rst_stall_cnt", stall_cnt, 8'h00);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // MEM and WB both match: MEM wins on both operands.
        mem_regwr = 1'b1; mem_rw = 5'd8; ex_rs = 5'd8; ex_rt = 5'd8;
        wb_regwr = 1'b1; wb_rw = 5'd8; mem_result = 8'h11; wb_din = 8'h22;
        ex_busa = 8'hAA; ex_busb = 8'hBB;
        #1;
        check("fwd_mem_prio_a", alu_a, 8'h11);
        check("fwd_mem_prio_b", alu_b, 8'h11);
        check("fwd_mem_prio_st", st_data, 8'h11);
        mem_regwr = 1'b0;
        #1;
        check("fwd_wb_a", alu_a, 8'h22);
        check("fwd_wb_b", alu_b, 8'h22);
        wb_regwr = 1'b0;
        #1;
        check("fwd_rf_a", alu_a, 8'hAA);
        check("fwd_rf_b", alu_b, 8'hBB);
        // Register 0 never forwards.
        mem_regwr = 1'b1; mem_rw = 5'd0; ex_rs = 5'd0;
        wb_regwr = 1'b1; wb_rw = 5'd0;
        #1;
        check("fwd_r0_a", alu_a, 8'hAA);

        // Load in MEM is not forwarded; WB value is used instead.
        clear_inputs();
        mem_regwr = 1'b1; mem_memtoreg = 1'b1; mem_rw = 5'd5; ex_rs = 5'd5;
        mem_result = 8'h55; wb_regwr = 1'b1; wb_rw = 5'd5; wb_din = 8'h33;
        ex_busa = 8'hAA;
        #1;
        check("fwd_load_skip_a", alu_a, 8'h33);

        // Immediate on B, forwarded rt on store data.
        clear_inputs();
        ex_alusrc = 1'b1; ex_imm = 8'h07; ex_rt = 5'd6; ex_busb = 8'hBB;
        mem_regwr = 1'b1; mem_rw = 5'd6; mem_result = 8'h44;
        #1;
        check("imm_alu_b", alu_b, 8'h07);
        check("imm_st_data", st_data, 8'h44);
        clear_inputs();

        // Load-use hazard on rs: one stalled cycle.
        tick();
        ex_memtoreg = 1'b1; ex_rw = 5'd9; id_rs = 5'd9;
        #1;
        check("lu_stall", stall, 1'b1);
        check("lu_flush", flush_ex, 1'b1);
        check("lu_cnt_before", stall_cnt, 8'(exp_cnt));
        tick();
        exp_cnt++;
        check("lu_cnt_after", stall_cnt, 8'(exp_cnt));
        ex_memtoreg = 1'b0;
        #1;
        check("lu_bubble_clear", stall, 1'b0);
        ex_memtoreg = 1'b1; ex_rw = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_use_rt = 1'b1;
        #1;
        check("lu_rt_stall", stall, 1'b1);
        id_use_rt = 1'b0;
        #1;
        check("lu_rt_unused", stall, 1'b0);
        ex_rw = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
        #1;
        check("lu_r0_no_stall", stall, 1'b0);
        clear_inputs();

        // mul/div start blocked by load-use, then accepted; mfhi stalls while busy.
        tick();
        ex_memtoreg = 1'b1; ex_rw = 5'd9; id_rs = 5'd9; id_md_start = 1'b1;
        #1;
        check("md_blocked_stall", stall, 1'b1);
        tick();
        exp_cnt++;
        check("md_blocked_idle", md_busy, 1'b0);
        check("md_blocked_cnt", stall_cnt, 8'(exp_cnt));
        ex_memtoreg = 1'b0;
        #1;
        check("md_start_unstalled", stall, 1'b0);
        tick();
        id_md_start = 1'b0; id_rs = 5'd0; ex_rw = 5'd0;
        id_hilo_rd = 1'b1;
        #1;
        check("md_busy_c1", md_busy, 1'b1);
        check("md_hilo_stall_c1", stall, 1'b1);
        for (int i = 2; i <= MD; i++) begin
            tick();
            exp_cnt++;
            check($sformatf("md_busy_c%0d", i), md_busy, 1'b1);
            check($sformatf("md_hilo_stall_c%0d", i), stall, 1'b1);
        end
        tick();
        exp_cnt++;
        check("md_busy_done", md_busy, 1'b0);
        check("md_hilo_free", stall, 1'b0);
        check("md_stall_cnt", stall_cnt, 8'(exp_cnt));
        id_hilo_rd = 1'b0;

        // Asynchronous reset in the middle of a busy period.
        id_md_start = 1'b1;
        tick();
        id_md_start = 1'b0;
        check("rb_busy", md_busy, 1'b1);
        id_hilo_rd = 1'b1;
        tick();
        exp_cnt++;
        check("rb_cnt", stall_cnt, 8'(exp_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_md_busy", md_busy, 1'b0);
        check("rb_stall_cnt", stall_cnt, 8'h00);
        check("rb_stall", stall, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        check("rb_after_busy", md_busy, 1'b0);
        check("rb_after_stall", stall, 1'b0);
        check("rb_after_cnt", stall_cnt, 8'h00);
        clear_inputs();

        // Saturation of the stall counter.
        ex_memtoreg = 1'b1; ex_rw = 5'd9; id_rs = 5'd9;
        repeat (254) tick();
        check("sat_fe", stall_cnt, 8'hFE);
        tick();
        check("sat_ff", stall_cnt, 8'hFF);
        repeat (5) tick();
        check("sat_hold", stall_cnt, 8'hFF);
        check("sat_stall", stall, 1'b1);
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
